// File: rtl/chroni_pkg.sv
// Shared constants and types for the Chroni scanline pixel path.
package chroni_pkg;

  localparam int CHRONI_LINE_BUFFER_SIZE = 1280;
  localparam int CHRONI_PIXEL_ADDR_W     = 11;
  localparam int CHRONI_HALF_LINE        = 640;

  typedef enum logic {
    EXP_IDLE,
    EXP_RUN
  } exp_state_e;

endpackage

// File: rtl/chroni_bitmap_expander.sv
// Serialises 1-bpp font bitmap bytes into palette-index pixel writes.
// CHRONI_EXPANDER_TRANSPARENT_EN: off colour 00 suppresses background writes.
module chroni_bitmap_expander
  import chroni_pkg::*;
#(
  parameter int BUFFER_SIZE = CHRONI_LINE_BUFFER_SIZE,
  parameter int ADDR_W      = CHRONI_PIXEL_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_bitmap,
  input  logic [7:0]        in_color_on,
  input  logic [7:0]        in_color_off,
  input  logic [3:0]        in_bits,
  output logic              busy,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [7:0]        ram_wr_data
);

  exp_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        on_q, on_d;
  logic [7:0]        off_q, off_d;
  logic [3:0]        count_q, count_d;

  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic last_px;
  logic can_load;
  logic run_d;
  logic px_on;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    shift_d    = shift_q;
    on_d       = on_q;
    off_d      = off_q;
    count_d    = count_q;

    last_px  = (state_q == EXP_RUN) && (count_q == 4'd1);
    can_load = (state_q == EXP_IDLE) || last_px;

    if (abort) begin
      state_d = EXP_IDLE;
      count_d = '0;
    end else if (can_load && in_valid && (in_bits != 4'd0)) begin
      state_d    = EXP_RUN;
      cur_addr_d = in_addr;
      shift_d    = in_bitmap;
      on_d       = in_color_on;
      off_d      = in_color_off;
      count_d    = (in_bits > 4'd8) ? 4'd8 : in_bits;
    end else if (state_q == EXP_RUN) begin
      shift_d    = {shift_q[6:0], 1'b0};
      cur_addr_d = (cur_addr_q == ADDR_W'(BUFFER_SIZE - 1))
                   ? '0 : cur_addr_q + 1'b1;
      count_d    = count_q - 4'd1;
      if (last_px) state_d = EXP_IDLE;
    end
  end

  // Outputs are registered from the next-state view so they track the pixel.
  always_comb begin
    run_d = (state_d == EXP_RUN);
    px_on = shift_d[7];
`ifdef CHRONI_EXPANDER_TRANSPARENT_EN
    wr_en_d = run_d && (px_on || (off_d != 8'h00));
`else
    wr_en_d = run_d;
`endif
    wr_addr_d = run_d ? cur_addr_d : wr_addr_q;
    wr_data_d = run_d ? (px_on ? on_d : off_d) : wr_data_q;
    busy_d    = run_d && (count_d != 4'd1);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EXP_IDLE;
      cur_addr_q <= '0;
      shift_q    <= '0;
      on_q       <= '0;
      off_q      <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      shift_q    <= shift_d;
      on_q       <= on_d;
      off_q      <= off_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_chroni_bitmap_expander.sv
// Directed and randomized checks of the bitmap expander against a pixel-list model.
module tb_chroni_bitmap_expander;

  localparam int BUF = 1280;
`ifdef CHRONI_EXPANDER_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] in_addr = '0;
  logic [7:0]  in_bitmap = '0;
  logic [7:0]  in_color_on = '0;
  logic [7:0]  in_color_off = '0;
  logic [3:0]  in_bits = '0;
  logic        busy;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;

  int tests = 0;
  int fails = 0;

  logic [10:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic        last_en = 1'b1;

  chroni_bitmap_expander dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_addr      (in_addr),
    .in_bitmap    (in_bitmap),
    .in_color_on  (in_color_on),
    .in_color_off (in_color_off),
    .in_bits      (in_bits),
    .busy         (busy),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic req(input logic [10:0] a, input logic [7:0] b,
                     input logic [7:0] on, input logic [7:0] off,
                     input logic [3:0] bits);
    in_valid     = 1'b1;
    in_addr      = a;
    in_bitmap    = b;
    in_color_on  = on;
    in_color_off = off;
    in_bits      = bits;
  endtask

  // Pixel k of a request: address a+k modulo the buffer, colour from bit 7-k.
  task automatic check_px(input logic [10:0] a, input logic [7:0] b,
                          input logic [7:0] on, input logic [7:0] off,
                          input int n, input int k);
    logic [10:0] ea;
    logic [7:0]  ed;
    logic        bv;
    logic        een;
    ea  = 11'((int'(a) + k) % BUF);
    bv  = b[7-k];
    ed  = bv ? on : off;
    een = !(TRANSP && (off == 8'h00) && !bv);
    chk("wr_en", 32'(ram_wr_en), 32'(een));
    chk("wr_addr", 32'(ram_wr_addr), 32'(ea));
    if (een) chk("wr_data", 32'(ram_wr_data), 32'(ed));
    chk("busy", 32'(busy), 32'(k != n - 1));
    last_addr = ea;
    last_en   = een;
    if (een) last_data = ed;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_addr"}, 32'(ram_wr_addr), 32'(last_addr));
    if (last_en) chk({tag, "_data"}, 32'(ram_wr_data), 32'(last_data));
  endtask

  task automatic run_one(input logic [10:0] a, input logic [7:0] b,
                         input logic [7:0] on, input logic [7:0] off,
                         input logic [3:0] bits);
    int n;
    n = (bits > 4'd8) ? 8 : int'(bits);
    req(a, b, on, off, bits);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      check_px(a, b, on, off, n, k);
      tick();
    end
    check_idle("idle");
  endtask

  initial begin
    #1;
    chk("rst_en", 32'(ram_wr_en), 32'd0);
    chk("rst_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_data", 32'(ram_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_idle("post_rst");

    // A5 pattern; a request presented mid-run must be dropped
    req(11'd0, 8'hA5, 8'h0F, 8'h01, 4'd8);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_px(11'd0, 8'hA5, 8'h0F, 8'h01, 8, k);
      if (k == 2) req(11'd100, 8'hFF, 8'hAA, 8'hBB, 4'd8);
      else in_valid = 1'b0;
      tick();
    end
    check_idle("a5_end");

    // back-to-back: second request rides the last pixel of the first
    req(11'd640, 8'hFF, 8'h11, 8'h22, 4'd8);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_px(11'd640, 8'hFF, 8'h11, 8'h22, 8, k);
      if (k == 7) req(11'd648, 8'h00, 8'h33, 8'h44, 4'd8);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_px(11'd648, 8'h00, 8'h33, 8'h44, 8, k);
      tick();
    end
    check_idle("b2b_end");

    run_one(11'd1276, 8'hFF, 8'h21, 8'h12, 4'd8);
    run_one(11'd50, 8'hC0, 8'h5A, 8'hA5, 4'd3);
    run_one(11'd60, 8'hFF, 8'h5A, 8'hA5, 4'd0);
    run_one(11'd70, 8'h3C, 8'h01, 8'h02, 4'd12);
    run_one(11'd200, 8'h81, 8'h55, 8'h00, 4'd8);

    // abort while the 4th pixel is on the bus
    req(11'd300, 8'hFF, 8'h66, 8'h77, 4'd8);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_px(11'd300, 8'hFF, 8'h66, 8'h77, 8, k);
      if (k < 3) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("abort1");
    tick();
    check_idle("abort2");

    abort = 1'b1;
    req(11'd400, 8'hFF, 8'h66, 8'h77, 4'd8);
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    check_idle("abort_vld1");
    tick();
    check_idle("abort_vld2");

    // asynchronous reset in the middle of a run
    req(11'd500, 8'hFF, 8'h99, 8'h88, 4'd8);
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(ram_wr_en), 32'd0);
    chk("mid_rst_addr", 32'(ram_wr_addr), 32'd0);
    chk("mid_rst_data", 32'(ram_wr_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    last_addr = '0;
    last_data = '0;
    last_en   = 1'b1;
    tick();
    check_idle("after_rst");

    for (int i = 0; i < 30; i++) begin
      logic [10:0] ra;
      logic [7:0]  rb;
      logic [7:0]  ron;
      logic [7:0]  roff;
      logic [3:0]  rn;
      ra   = 11'($urandom_range(0, BUF - 1));
      rb   = 8'($urandom);
      ron  = 8'($urandom);
      roff = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rn   = 4'($urandom_range(0, 15));
      run_one(ra, rb, ron, roff, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
